// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Single-cycle ops pass through EXEC. MUL is an
// iterative shift-add that retires one partial product per cycle.
// Result and Z/N flags are registered on entry to DONE, and the block
// pulses done/status_wr_out for that one cycle.
module alu_seq #(
    parameter int DATA_WIDTH = 11
) (
    input  logic                  clock,
    input  logic                  status_reset,
    input  logic                  start,
    input  logic [2:0]            op_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic                  zero_indicator_out,
    output logic                  signal_bit_out,
    output logic                  status_wr_out
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d, res_q, res_d;
    logic [2:0]            op_q, op_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  z_q, z_d, n_q, n_d;
    logic [DATA_WIDTH-1:0] alu_res, mul_sum;

    // Single-cycle datapath on the captured operands (MUL has its own path)
    always_comb begin
        alu_res = '0;
        case (op_q)
            3'b000:  alu_res = a_q + b_q;
            3'b001:  alu_res = a_q - b_q;
            3'b010:  alu_res = a_q & b_q;
            3'b011:  alu_res = a_q | b_q;
            3'b100:  alu_res = a_q ^ b_q;
            3'b101:  alu_res = ~a_q;
            3'b110:  alu_res = b_q;
            default: alu_res = '0;
        endcase
        // The multiplicand (a_q) shifts left and the multiplier (b_q) shifts right in MUL
        mul_sum = acc_q + (b_q[0] ? a_q : '0);
    end

    // Next-state, datapath updates and status outputs
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        res_d         = res_q;
        z_d           = z_q;
        n_d           = n_q;
        busy          = (state_q != IDLE);
        done          = (state_q == DONE);
        status_wr_out = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    op_d    = op_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (op_in == 3'b111) ? MUL : EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_res;
                z_d     = (alu_res == '0);
                n_d     = alu_res[DATA_WIDTH-1];
                state_d = DONE;
            end
            MUL: begin
                acc_d = mul_sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    res_d   = mul_sum;
                    z_d     = (mul_sum == '0);
                    n_d     = mul_sum[DATA_WIDTH-1];
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clock or posedge status_reset) begin
        if (status_reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    assign result_out         = res_q;
    assign zero_indicator_out = z_q;
    assign signal_bit_out     = n_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: transaction-level model (operation result plus fixed
// latency) checked every cycle, directed scenarios with literal expectations,
// then randomized traffic with sporadic resets.
module tb_alu_seq;
    localparam int W = 11;

    logic         clock = 1'b0;
    logic         status_reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op_in = '0;
    logic [W-1:0] a_in = '0, b_in = '0;
    logic         busy, done, zero_indicator_out, signal_bit_out, status_wr_out;
    logic [W-1:0] result_out;

    int total = 0;
    int bad = 0;

    alu_seq #(.DATA_WIDTH(W)) dut (
        .clock(clock), .status_reset(status_reset), .start(start), .op_in(op_in),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .result_out(result_out),
        .zero_indicator_out(zero_indicator_out), .signal_bit_out(signal_bit_out),
        .status_wr_out(status_wr_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result straight from the opcode table, modulo 2^W
    function automatic int ref_op(input int op, input int a, input int b);
        int m = (1 << W);
        case (op)
            0: return (a + b) % m;
            1: return (a - b + m) % m;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (~a) & (m - 1);
            6: return b;
            default: return (a * b) % m;
        endcase
    endfunction

    // Model: an accepted op completes a fixed number of edges later
    // (2 for single-cycle ops, W+1 for MUL), then one idle-return edge.
    bit m_active = 0;
    int m_cnt = 0, m_lat = 0, m_pend = 0, m_res = 0;
    bit m_z = 0, m_n = 0;

    always @(posedge clock or posedge status_reset) begin
        if (status_reset) begin
            m_active = 0; m_cnt = 0; m_lat = 0; m_res = 0; m_z = 0; m_n = 0;
        end else if (m_active && m_cnt == m_lat) begin
            m_active = 0;
        end else if (m_active) begin
            m_cnt++;
            if (m_cnt == m_lat) begin
                m_res = m_pend;
                m_z   = (m_pend == 0);
                m_n   = ((m_pend >> (W - 1)) & 1) != 0;
            end
        end else if (start) begin
            m_active = 1;
            m_cnt    = 1;
            m_lat    = (op_in == 3'd7) ? W + 1 : 2;
            m_pend   = ref_op(int'(op_in), int'(a_in), int'(b_in));
        end
    end

    // Compare every cycle, settled after the active edge
    always @(posedge clock) begin
        #1;
        check("busy", int'(busy), int'(m_active));
        check("done", int'(done), int'(m_active && m_cnt == m_lat));
        check("status_wr", int'(status_wr_out), int'(m_active && m_cnt == m_lat));
        check("result", int'(result_out), m_res);
        check("zflag", int'(zero_indicator_out), int'(m_z));
        check("nflag", int'(signal_bit_out), int'(m_n));
    end

    // Issue one op at the current negedge and check latency/result literally
    task automatic do_op(input string name, input logic [2:0] op, input int a, input int b,
                         input int exp_res, input int exp_edges, input bit exp_z, input bit exp_n);
        int edges;
        start = 1'b1; op_in = op; a_in = W'(a); b_in = W'(b);
        @(negedge clock);
        start = 1'b0; a_in = '0; b_in = '0;
        edges = 1;
        while (!done && edges < 60) begin
            @(negedge clock);
            edges++;
        end
        check({name, "_lat"}, edges, exp_edges);
        check({name, "_res"}, int'(result_out), exp_res);
        check({name, "_z"}, int'(zero_indicator_out), int'(exp_z));
        check({name, "_n"}, int'(signal_bit_out), int'(exp_n));
        check({name, "_wr"}, int'(status_wr_out), 1);
        @(negedge clock);
    endtask

    initial begin
        int edges;
        repeat (3) @(negedge clock);
        check("rst_busy", int'(busy), 0);
        check("rst_res", int'(result_out), 0);
        check("rst_z", int'(zero_indicator_out), 0);
        // First start accepted on the first edge after release
        status_reset = 1'b0;
        do_op("add", 3'd0, 5, 3, 8, 2, 0, 0);
        do_op("sub0", 3'd1, 3, 3, 0, 2, 1, 0);
        do_op("subneg", 3'd1, 0, 1, 'h7FF, 2, 0, 1);
        do_op("mul", 3'd7, 12, 13, 156, 12, 0, 0);
        do_op("mulovf", 3'd7, 64, 64, 0, 12, 1, 0);
        do_op("not", 3'd5, 'h0F0, 0, 'h70F, 2, 0, 1);
        do_op("passb", 3'd6, 9, 'h400, 'h400, 2, 0, 1);

        // Busy rejection: a second request during MUL is dropped
        start = 1'b1; op_in = 3'd7; a_in = 2; b_in = 3;
        @(negedge clock);
        start = 1'b0;
        edges = 1;
        repeat (2) begin @(negedge clock); edges++; end
        start = 1'b1; op_in = 3'd0; a_in = 100; b_in = 100;
        repeat (2) begin @(negedge clock); edges++; end
        start = 1'b0;
        check("rej_flags_held", int'(result_out), 'h400);
        while (!done && edges < 60) begin @(negedge clock); edges++; end
        check("rej_lat", edges, 12);
        check("rej_res", int'(result_out), 6);
        @(negedge clock);
        check("rej_idle", int'(busy), 0);
        @(negedge clock);
        check("rej_no_second", int'(busy), 0);

        // Reset five cycles into MUL aborts at once
        start = 1'b1; op_in = 3'd7; a_in = 12; b_in = 13;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        status_reset = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_res", int'(result_out), 0);
        check("abort_n", int'(signal_bit_out), 0);
        repeat (2) @(negedge clock);
        status_reset = 1'b0;
        do_op("add11", 3'd0, 1, 1, 2, 2, 0, 0);

        // Randomized traffic, including held start and occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                status_reset = 1'b1;
                start = 1'b0;
            end else begin
                status_reset = 1'b0;
                start = ($urandom_range(0, 2) == 0);
                op_in = 3'($urandom_range(0, 7));
                a_in  = W'($urandom);
                b_in  = W'($urandom);
            end
            @(negedge clock);
        end
        start = 1'b0;
        status_reset = 1'b0;
        repeat (20) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
